// File: rtl/ysyx_24100029_ifu.sv
// Instruction fetch unit: one outstanding single-beat read, a redirect-aware discard path,
// and an optional perf-counter pair enabled by the IFU_PERF_CNT_EN macro.
module ysyx_24100029_ifu #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h3000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              master_valid,
    input  logic              master_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt,
    output logic [1:0]        dbg_state
);

    // All three channels (ar, r, master) use the same rule: a transfer happens on a rising
    // edge where valid and ready are both high; valid never drops and its payload never
    // changes until that transfer, except that a redirect withdraws master_valid.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [1:0]  OKAY   = 2'b00;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] next_pc_q;
    logic              discard_q;
    logic              arvalid_q;
    logic              rready_q;

    assign araddr       = fetch_pc_q;
    assign arvalid      = arvalid_q;
    assign rready       = rready_q;
    assign dbg_state    = state;
    // Gated combinationally so a wrong-path word is never handed to decode.
    assign master_valid = (state == S_OUT) && !redirect_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_REQ;
            fetch_pc_q <= RESET_PC;
            next_pc_q  <= RESET_PC;
            discard_q  <= 1'b0;
            inst       <= 32'h0;
            pc         <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        next_pc_q <= redirect_pc;
                        discard_q <= 1'b1;
                    end
                    // arvalid_q is low only in the first cycle after reset release.
                    if (arvalid_q && arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        arvalid_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rvalid && rready_q) begin
                        rready_q <= 1'b0;
                        if (discard_q || redirect_valid) begin
                            fetch_pc_q <= redirect_valid ? redirect_pc : next_pc_q;
                            discard_q  <= 1'b0;
                            arvalid_q  <= 1'b1;
                            state      <= S_REQ;
                        end else begin
                            inst  <= (rresp == OKAY) ? rdata : EBREAK;
                            pc    <= fetch_pc_q;
                            state <= S_OUT;
                        end
                    end else if (redirect_valid) begin
                        next_pc_q <= redirect_pc;
                        discard_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        arvalid_q  <= 1'b1;
                        state      <= S_REQ;
                    end else if (master_ready) begin
                        fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
                        arvalid_q  <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state     <= S_REQ;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (master_valid && master_ready)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (master_valid && !master_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = 32'h0;
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// Bench for ysyx_24100029_ifu: directed fetch table, multi-cycle corner sequences, then a
// randomized run checked against a delivered-stream model; builds with or without IFU_PERF_CNT_EN.
module tb_ysyx_24100029_ifu;

    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
`ifdef IFU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        master_valid;
    logic        master_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [1:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    ysyx_24100029_ifu #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .master_valid(master_valid), .master_ready(master_ready),
        .inst(inst), .pc(pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return a[6:2] == 5'd7;
    endfunction

    function automatic logic [31:0] exp_cnt(input int n);
        return PERF ? 32'(n) : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Advance to the drive point just after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for arvalid, check its address, then accept it with a one-cycle arready.
    task automatic ar_accept(input logic [31:0] exp_pc);
        int k;
        k = 0;
        @(negedge clock);
        while (!arvalid && k < 20) begin
            cyc();
            @(negedge clock);
            k++;
        end
        chk("ar_wait", 32'(arvalid), 32'd1);
        chk("araddr", araddr, exp_pc);
        cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
    endtask

    task automatic fetch_to_out(input logic [31:0] exp_pc, input logic [1:0] resp, input int delay);
        ar_accept(exp_pc);
        repeat (delay) cyc();
        rvalid = 1'b1;
        rdata  = mem_word(exp_pc);
        rresp  = resp;
        cyc();
        rvalid = 1'b0;
        rresp  = 2'b00;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  resp;
        int          delay;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl[6];

    // Random-phase model state
    logic [31:0] exp_pc;
    logic [31:0] pend_q[$];
    int          rdelay;
    bit          prev_ar_wait;
    logic [31:0] prev_araddr;
    int          fire_tot, stall_tot, last_fire;
    bit          zw, ar_fire, r_fire, m_fire;

    initial begin
        tbl[0] = '{32'h3000_0000, 2'b00, 0, mem_word(32'h3000_0000)};
        tbl[1] = '{32'h3000_0004, 2'b00, 2, mem_word(32'h3000_0004)};
        tbl[2] = '{32'h3000_0008, 2'b00, 0, mem_word(32'h3000_0008)};
        tbl[3] = '{32'h3000_000C, 2'b00, 3, mem_word(32'h3000_000C)};
        tbl[4] = '{32'h3000_0010, 2'b10, 1, EBREAK};
        tbl[5] = '{32'h3000_0014, 2'b00, 0, mem_word(32'h3000_0014)};

        // Reset state
        repeat (3) cyc();
        @(negedge clock);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_mvalid", 32'(master_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);
        cyc();
        reset = 1'b1;
        cyc();
        @(negedge clock);
        chk("rel_arvalid", 32'(arvalid), 32'd1);
        chk("rel_araddr", araddr, RESET_PC);
        cyc();

        // Directed fetch table, decode always ready
        master_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fetch_to_out(tbl[i].pc, tbl[i].resp, tbl[i].delay);
            @(negedge clock);
            chk("tbl_mvalid", 32'(master_valid), 32'd1);
            chk("tbl_inst", inst, tbl[i].inst);
            chk("tbl_pc", pc, tbl[i].pc);
            cyc();
        end
        @(negedge clock);
        chk("tbl_fetch_cnt", fetch_cnt, exp_cnt(6));
        chk("tbl_stall_cnt", stall_cnt, exp_cnt(0));
        cyc();

        // Decode stalls for 5 cycles
        master_ready = 1'b0;
        fetch_to_out(32'h3000_0018, 2'b00, 1);
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            chk("stall_mvalid", 32'(master_valid), 32'd1);
            chk("stall_inst", inst, mem_word(32'h3000_0018));
            chk("stall_pc", pc, 32'h3000_0018);
            chk("stall_no_ar", 32'(arvalid), 32'd0);
            cyc();
        end
        master_ready = 1'b1;
        @(negedge clock);
        chk("stall_cnt5", stall_cnt, exp_cnt(5));
        chk("stall_fetch_cnt", fetch_cnt, exp_cnt(6));
        cyc();

        // Redirect while waiting on a slow response
        ar_accept(32'h3000_001C);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0100;
        @(negedge clock);
        chk("resp_redir_mvalid", 32'(master_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            chk("resp_wait_mvalid", 32'(master_valid), 32'd0);
            cyc();
        end
        rvalid = 1'b1;
        rdata  = mem_word(32'h3000_001C);
        cyc();
        rvalid = 1'b0;
        @(negedge clock);
        chk("drop_mvalid", 32'(master_valid), 32'd0);
        chk("drop_arvalid", 32'(arvalid), 32'd1);
        chk("drop_araddr", araddr, 32'h3000_0100);
        cyc();
        fetch_to_out(32'h3000_0100, 2'b00, 0);
        @(negedge clock);
        chk("redir_tgt_pc", pc, 32'h3000_0100);
        chk("redir_tgt_inst", inst, mem_word(32'h3000_0100));
        cyc();

        // Redirect in S_OUT coincident with master_ready
        fetch_to_out(32'h3000_0104, 2'b00, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0200;
        @(negedge clock);
        chk("out_redir_mvalid", 32'(master_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("out_redir_arvalid", 32'(arvalid), 32'd1);
        chk("out_redir_araddr", araddr, 32'h3000_0200);
        chk("out_redir_fetch_cnt", fetch_cnt, exp_cnt(8));
        cyc();
        fetch_to_out(32'h3000_0200, 2'b00, 0);
        @(negedge clock);
        chk("out_tgt_pc", pc, 32'h3000_0200);
        cyc();

        // Asynchronous reset while arvalid is stalled
        arready = 1'b0;
        @(negedge clock);
        chk("pre_rst_arvalid", 32'(arvalid), 32'd1);
        cyc();
        #2 reset = 1'b0;
        #1;
        chk("arst_arvalid", 32'(arvalid), 32'd0);
        chk("arst_rready", 32'(rready), 32'd0);
        chk("arst_mvalid", 32'(master_valid), 32'd0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_fetch_cnt", fetch_cnt, 32'h0);
        chk("arst_stall_cnt", stall_cnt, 32'h0);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        @(negedge clock);
        chk("arst_rel_arvalid", 32'(arvalid), 32'd1);
        chk("arst_rel_araddr", araddr, RESET_PC);
        cyc();

        // Randomized run: zero-wait warm-up, then random memory/decode/redirect behaviour
        exp_pc       = RESET_PC;
        rdelay       = 0;
        prev_ar_wait = 1'b0;
        prev_araddr  = 32'h0;
        fire_tot     = 0;
        stall_tot    = 0;
        last_fire    = -1;
        for (int i = 0; i < 3000; i++) begin
            zw      = (i < 40);
            arready = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (pend_q.size() != 0 && rdelay == 0) begin
                rvalid = 1'b1;
                rdata  = mem_word(pend_q[0]);
                rresp  = is_err(pend_q[0]) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
                rdata  = $urandom;
                rresp  = 2'b00;
            end
            master_ready   = zw ? 1'b1 : ($urandom_range(0, 3) != 0);
            redirect_valid = zw ? 1'b0 : ($urandom_range(0, 11) == 0);
            redirect_pc    = RESET_PC + 32'($urandom_range(0, 63) << 2);

            @(negedge clock);
            ar_fire = arvalid && arready;
            r_fire  = rvalid && rready;
            m_fire  = master_valid && master_ready;
            if (redirect_valid) chk("rnd_mvalid_gated", 32'(master_valid), 32'd0);
            if (prev_ar_wait) begin
                chk("rnd_ar_hold", 32'(arvalid), 32'd1);
                chk("rnd_araddr_stable", araddr, prev_araddr);
            end
            if (m_fire) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_inst", inst, is_err(exp_pc) ? EBREAK : mem_word(exp_pc));
                if (zw && last_fire >= 0) chk("rnd_throughput", 32'(i - last_fire), 32'd3);
                last_fire = i;
                fire_tot++;
            end
            if (master_valid && !master_ready) stall_tot++;
            if (redirect_valid) exp_pc = redirect_pc;
            else if (m_fire) exp_pc = exp_pc + 32'd4;
            if (r_fire) void'(pend_q.pop_front());
            else if (pend_q.size() != 0 && rdelay > 0) rdelay--;
            if (ar_fire) begin
                chk("rnd_one_outstanding", 32'(pend_q.size()), 32'd0);
                pend_q.push_back(araddr);
                rdelay = zw ? 0 : int'($urandom_range(0, 3));
            end
            prev_ar_wait = arvalid && !arready;
            prev_araddr  = araddr;
            cyc();
        end
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("rnd_fetch_cnt", fetch_cnt, exp_cnt(fire_tot));
        chk("rnd_stall_cnt", stall_cnt, exp_cnt(stall_tot));
        chk("rnd_progress", 32'(fire_tot > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_24100029_ifu.md
Name: ysyx_24100029_ifu

Overview:
Instruction fetch unit; the producer end of the decode-stage slave handshake (inst/pc, valid/ready).
- Holds the fetch PC and issues single-beat reads on an AXI4-Lite-style read channel to instruction memory.
- Presents each returned word with its PC to decode, and accepts redirects from execute/trap logic.
- One fetch outstanding at a time. Wrong-path responses are discarded.

Parameters:
RESET_PC, 32'h3000_0000, first fetch address after reset release
ADDR_W, 32, address and PC width

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
araddr  out  ADDR_W  read address
arvalid  out  1  read address valid
arready  in  1  memory accepts address
rdata  in  32  read data
rresp  in  2  read response; 0 = OKAY
rvalid  in  1  read data valid
rready  out  1  IFU accepts read data
master_valid  out  1  inst/pc valid to decode
master_ready  in  1  decode accepts
inst  out  32  fetched instruction
pc  out  ADDR_W  PC of inst
redirect_valid  in  1  one-cycle PC redirect (branch/jump/trap/mret/fence.i)
redirect_pc  in  ADDR_W  redirect target
fetch_cnt  out  32  delivered-instruction counter (see Optional Feature)
stall_cnt  out  32  cycles with master_valid & ~master_ready

Behaviour:
- Reset (reset==0, asynchronous):
  - State=S_REQ. fetch_pc_q=RESET_PC, next_pc_q=RESET_PC, discard_q=0.
  - Outputs: inst=0, pc=0, master_valid=0, arvalid=0, rready=0, counters=0.
- Reset release: arvalid=1 with araddr=RESET_PC in the first clock after deassertion.
- Reset mid-transaction abandons any outstanding read. The memory side is reset together with the IFU.
- State S_REQ:
  - arvalid=1, araddr=fetch_pc_q. araddr stays stable until arready.
  - Go to S_RESP on arready.
- State S_RESP:
  - rready=1.
  - On rvalid with discard_q=0: inst<=rdata, pc<=fetch_pc_q, go to S_OUT.
  - On rvalid with discard_q=1: drop the data, fetch_pc_q<=next_pc_q, discard_q<=0, go to S_REQ.
- State S_OUT:
  - master_valid=(state==S_OUT)&~redirect_valid. This is combinationally gated so a wrong-path inst is never handed over.
  - On master_valid&master_ready: fetch_pc_q<=fetch_pc_q+4 (mod 2^ADDR_W, wraps silently), go to S_REQ.
  - inst/pc stay stable while master_valid&~master_ready.
- Redirect:
  - In S_OUT: fetch_pc_q<=redirect_pc, go to S_REQ. The redirect wins over a simultaneous master_ready, so no transfer occurs.
  - In S_REQ or S_RESP: next_pc_q<=redirect_pc, discard_q<=1. The in-flight request completes and is dropped.
  - A second redirect before the discard completes overwrites next_pc_q; the last one wins.
  - rvalid together with redirect in S_RESP: data dropped, next fetch from redirect_pc.
- Response error: rresp!=0 with discard_q=0 latches inst=32'h0010_0073 (ebreak) and the faulting pc, so the trap path sees it.
- Throughput: minimum 3 cycles per instruction (REQ, RESP, OUT) with zero-wait memory.
- Latency:
  - Redirect in S_OUT to arvalid at the new address: 1 cycle.
  - Redirect in S_OUT to master_valid of the target: 3 cycles minimum.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined:
  - fetch_cnt increments on each master_valid&master_ready.
  - stall_cnt increments on each cycle with master_valid&~master_ready.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built. Fetch behaviour is identical either way.

Test Plan:
- Reset release, zero-wait memory, master_ready=1 -> araddr sequence 0x3000_0000, 0x3000_0004, 0x3000_0008; inst/pc pairs match memory; master_valid every 3rd cycle.
- master_ready=0 for 5 cycles in S_OUT -> inst/pc stable, no new arvalid, stall_cnt=5 (with IFU_PERF_CNT_EN).
- redirect_valid, redirect_pc=0x3000_0100 while in S_RESP with rvalid delayed 4 cycles -> returned word dropped (master_valid stays 0), next araddr=0x3000_0100.
- redirect in S_OUT coincident with master_ready=1 -> master_valid=0 that cycle, fetch_cnt unchanged, next araddr=redirect_pc.
- rresp=2'b10 on fetch at 0x3000_0010 -> inst=0x0010_0073, pc=0x3000_0010.
- reset asserted while arvalid high and arready held 0 -> all outputs 0 immediately (asynchronous); after release araddr=RESET_PC.
